// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: registered LED drive, synchronized and debounced switch
// inputs, and a change flag that raises a maskable level interrupt.
module mmio_gpio #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [7:0]  switches,
    output logic [7:0]  leds,
    output logic        irq
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bus handshake: we and re are single-cycle strobes with no back-pressure.
    // A store commits on the edge that samples we=1.
    // A load is answered combinationally in the same cycle as re=1.
    logic       w_hit;
    logic [1:0] w_sel;
    logic       w_wr_led;
    logic       w_wr_status;
    logic       w_wr_ctrl;
    logic       w_unused;

    assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_sel       = addr[3:2];
    assign w_wr_led    = we && w_hit && (w_sel == 2'd0);
    assign w_wr_status = we && w_hit && (w_sel == 2'd2);
    assign w_wr_ctrl   = we && w_hit && (w_sel == 2'd3);
    assign w_unused    = ^{addr[1:0], wdata[31:8]};

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_cand;
    logic [7:0]       r_sw_db;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_leds;
    logic             r_chg;
    logic             r_ie;

    // Any bit differing from the candidate restarts the whole vector's count.
    logic w_restart;
    logic w_pending;
    logic w_accept;

    assign w_restart = (r_sync2 != r_cand);
    assign w_pending = (r_cand != r_sw_db);
    assign w_accept  = !w_restart && w_pending && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_sw_db <= '0;
            r_cnt   <= '0;
            r_leds  <= '0;
            r_chg   <= 1'b0;
            r_ie    <= 1'b0;
        end else begin
            r_sync1 <= switches;
            r_sync2 <= r_sync1;

            if (w_restart) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (w_accept) begin
                r_sw_db <= r_cand;
                r_cnt   <= '0;
            end else if (w_pending) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_wr_led) begin
                r_leds <= wdata[7:0];
            end
            if (w_wr_ctrl) begin
                r_ie <= wdata[0];
            end

            // A new debounced change outranks a same-edge software clear.
            if (w_accept) begin
                r_chg <= 1'b1;
            end else if (w_wr_status && wdata[0]) begin
                r_chg <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (re && w_hit) begin
            case (w_sel)
                2'd0:    rdata = {24'h0, r_leds};
                2'd1:    rdata = {24'h0, r_sw_db};
                2'd2:    rdata = {31'h0, r_chg};
                default: rdata = {31'h0, r_ie};
            endcase
        end
    end

    assign leds = r_leds;
    assign irq  = r_chg & r_ie;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio: table of single-cycle bus vectors, then
// hand-written debounce, interrupt, W1C-collision and reset sequences.
module tb_mmio_gpio;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          DB   = 4;
    localparam int          NVEC = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic [7:0]  switches;
    logic [7:0]  leds;
    logic        irq;

    always #5 clk = ~clk;

    mmio_gpio #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .switches(switches),
        .leds    (leds),
        .irq     (irq)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_leds;
        logic        exp_irq;
    } vec_t;

    vec_t        vecs[NVEC];
    logic [31:0] exp_q[$];
    logic [31:0] v;
    int          checks   = 0;
    int          failures = 0;

    function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] er,
                                input logic [7:0] el, input logic ei);
        vec_t t;
        t.we = w; t.re = r; t.addr = a; t.wdata = d;
        t.exp_rdata = er; t.exp_leds = el; t.exp_irq = ei;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] val);
        addr = BASE + {28'h0, off};
        re   = 1'b1;
        #1;
        val  = rdata;
        re   = 1'b0;
        addr = 32'h0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        addr  = BASE + {28'h0, off};
        wdata = d;
        we    = 1'b1;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, BASE + 32'h0,  32'h55,       32'h0,  8'h55, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, BASE + 32'h0,  32'h0,        32'h55, 8'h55, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, BASE + 32'h3,  32'h0,        32'h55, 8'h55, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, BASE + 32'h4,  32'hFF,       32'h0,  8'h55, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, BASE + 32'h10, 32'hAA,       32'h0,  8'h55, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, BASE + 32'h10, 32'h0,        32'h0,  8'h55, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, BASE + 32'h4,  32'h0,        32'h0,  8'h55, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, BASE + 32'hC,  32'hFFFFFFFF, 32'h0,  8'h55, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, BASE + 32'hC,  32'h0,        32'h1,  8'h55, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, BASE + 32'h0,  32'h0,        32'h0,  8'h55, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, BASE + 32'h0,  32'hA5,       32'h55, 8'hA5, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 32'h0000_0000, 32'h0,        32'h0,  8'hA5, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, BASE + 32'h8,  32'h0,        32'h0,  8'hA5, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, BASE + 32'hC,  32'h0,        32'h0,  8'hA5, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, BASE + 32'hC,  32'h0,        32'h0,  8'hA5, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, BASE + 32'h1,  32'h3C,       32'h0,  8'h3C, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, BASE + 32'h2,  32'h0,        32'h3C, 8'h3C, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 32'hFFFE_0000, 32'h77,       32'h0,  8'h3C, 1'b0);

        // Reset, with a store and a load presented while rst is high.
        switches = 8'h00;
        rst   = 1'b1;
        addr  = BASE;
        wdata = 32'h5A;
        we    = 1'b1;
        re    = 1'b0;
        tick();
        tick();
        re = 1'b1;
        #1;
        check("rst_rdata", rdata, 32'h0);
        idle();
        rst = 1'b0;
        check("rst_leds", {24'h0, leds}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4), v);
            check($sformatf("rst_reg%0d", i), v, 32'h0);
        end

        // Bus vectors: rdata checked before the edge, leds/irq after it.
        for (int i = 0; i < NVEC; i++) begin
            we = vecs[i].we; re = vecs[i].re;
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            tick();
            idle();
            check($sformatf("vec%0d_leds", i), {24'h0, leds}, {24'h0, vecs[i].exp_leds});
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // Debounce latency: 8'hAA held from edge 0 shows on SW after edge DB+2.
        switches = 8'hAA;
        for (int k = 0; k <= DB + 2; k++) begin
            exp_q.push_back((k < DB + 2) ? 32'h0 : 32'hAA);
        end
        for (int k = 0; k <= DB + 2; k++) begin
            tick();
            rd(4'h4, v);
            check($sformatf("deb_sw_e%0d", k), v, exp_q.pop_front());
            rd(4'h8, v);
            check($sformatf("deb_chg_e%0d", k), v, (k < DB + 2) ? 32'h0 : 32'h1);
        end
        check("deb_irq_masked", {31'h0, irq}, 32'h0);
        wr(4'h8, 32'h0);
        rd(4'h8, v);
        check("w1c_zero_keeps", v, 32'h1);
        wr(4'h8, 32'h1);
        rd(4'h8, v);
        check("w1c_one_clears", v, 32'h0);

        // Three-cycle glitch must never qualify.
        switches = 8'h00;
        do_reset();
        switches = 8'hFF;
        tick();
        tick();
        tick();
        switches = 8'h00;
        for (int k = 0; k < 12; k++) begin
            tick();
            rd(4'h4, v);
            check($sformatf("glitch_sw_%0d", k), v, 32'h0);
        end
        rd(4'h8, v);
        check("glitch_chg", v, 32'h0);

        // Interrupt rises with CHG when enabled, falls after W1C.
        wr(4'hC, 32'h1);
        rd(4'hC, v);
        check("ie_set", v, 32'h1);
        switches = 8'h0F;
        for (int k = 0; k <= DB + 2; k++) begin
            tick();
            check($sformatf("irq_e%0d", k), {31'h0, irq}, (k < DB + 2) ? 32'h0 : 32'h1);
        end
        wr(4'h8, 32'h0);
        check("irq_w1c_zero", {31'h0, irq}, 32'h1);
        wr(4'h8, 32'h1);
        check("irq_w1c_clear", {31'h0, irq}, 32'h0);

        // W1C landing on the same edge as a debounced update: set wins.
        switches = 8'hF0;
        for (int k = 0; k < DB + 2; k++) begin
            tick();
            rd(4'h4, v);
            check($sformatf("coll_sw_e%0d", k), v, 32'h0F);
        end
        rd(4'h8, v);
        check("coll_chg_before", v, 32'h0);
        wr(4'h8, 32'h1);
        rd(4'h8, v);
        check("coll_chg_after", v, 32'h1);
        rd(4'h4, v);
        check("coll_sw_after", v, 32'hF0);
        check("coll_irq", {31'h0, irq}, 32'h1);
        wr(4'h8, 32'h1);

        // Reset mid-debounce discards the pending change, then it re-qualifies.
        switches = 8'h3C;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(4'h4, v);
        check("midrst_sw", v, 32'h0);
        rd(4'h8, v);
        check("midrst_chg", v, 32'h0);
        for (int k = 0; k <= DB + 2; k++) begin
            tick();
            rd(4'h4, v);
            check($sformatf("requal_sw_e%0d", k), v, (k < DB + 2) ? 32'h0 : 32'h3C);
            rd(4'h8, v);
            check($sformatf("requal_chg_e%0d", k), v, (k < DB + 2) ? 32'h0 : 32'h1);
        end
        check("requal_irq", {31'h0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
